// File: rtl/spi_mem_master.sv
// spi_mem_master: SPI mode-0 master for 25xx-series EEPROMs, one byte per request.
// A read is a single 0x03 frame. A write is a WREN (0x06) frame followed by a
// WRITE (0x02) frame.
// Optional macro SPI_MEM_MASTER_WIP_POLL_EN: after the WRITE frame, poll RDSR (0x05)
// until the WIP bit clears. Without it, finish pulses right after the write frame.
module spi_mem_master #(
    parameter int CLK_DIV = 25,
    parameter int CS_GAP  = 50
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        begin_rd,
    input  logic        begin_wr,
    output logic        finish,
    input  logic [15:0] addr,
    input  logic [7:0]  data_wr,
    output logic [7:0]  data_rd,
    output logic        busy,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs
);

    // Top-level sequencing states; the frame kind selects what gets shifted.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GAP  = 3'd1;
    localparam logic [2:0] S_XFER = 3'd2;
    localparam logic [2:0] S_TAIL = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] K_WREN = 2'd0;
    localparam logic [1:0] K_CMD  = 2'd1;
`ifdef SPI_MEM_MASTER_WIP_POLL_EN
    localparam logic [1:0] K_POLL = 2'd2;
`endif

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'((CS_GAP > 0) ? (CS_GAP - 1) : 0);

    logic [2:0]  state;
    logic [1:0]  kind;
    logic        is_wr;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [31:0] shift_out;
    logic [7:0]  shift_in;
    logic [15:0] gap_cnt;
    logic        miso_s1;
    logic        miso_s2;
    logic [31:0] frame_word;
    logic [5:0]  frame_last;

    // Build the left-aligned frame to send and its last bit index for the current kind.
    always_comb begin
        frame_word = 32'h0;
        frame_last = 6'd7;
        case (kind)
            K_WREN: begin
                frame_word = {8'h06, 24'h0};
                frame_last = 6'd7;
            end
            K_CMD: begin
                frame_word = {(is_wr ? 8'h02 : 8'h03), addr_q, (is_wr ? data_q : 8'h00)};
                frame_last = 6'd31;
            end
`ifdef SPI_MEM_MASTER_WIP_POLL_EN
            K_POLL: begin
                frame_word = {8'h05, 24'h0};
                frame_last = 6'd15;
            end
`endif
            default: begin
                frame_word = 32'h0;
                frame_last = 6'd7;
            end
        endcase
    end

    // Two-flop synchroniser for the asynchronous MISO pin.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= spi_miso;
            miso_s2 <= miso_s1;
        end
    end

    // Request handling, CS gap timing, bit shifting and frame sequencing.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            kind      <= K_WREN;
            is_wr     <= 1'b0;
            addr_q    <= 16'h0;
            data_q    <= 8'h0;
            div_cnt   <= 8'h0;
            bit_cnt   <= 6'h0;
            shift_out <= 32'h0;
            shift_in  <= 8'h0;
            gap_cnt   <= 16'h0;
            finish    <= 1'b0;
            busy      <= 1'b0;
            data_rd   <= 8'h0;
            spi_cs    <= 1'b1;
            spi_clk   <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            finish <= 1'b0;
            if (spi_cs && gap_cnt != 16'hFFFF) begin
                gap_cnt <= gap_cnt + 16'd1;
            end

            case (state)
                S_IDLE: begin
                    if (begin_rd) begin
                        addr_q <= addr;
                        data_q <= data_wr;
                        is_wr  <= 1'b0;
                        kind   <= K_CMD;
                        busy   <= 1'b1;
                        state  <= S_GAP;
                    end else if (begin_wr) begin
                        addr_q <= addr;
                        data_q <= data_wr;
                        is_wr  <= 1'b1;
                        kind   <= K_WREN;
                        busy   <= 1'b1;
                        state  <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (gap_cnt >= GAP_LAST) begin
                        spi_cs    <= 1'b0;
                        spi_clk   <= 1'b0;
                        spi_mosi  <= frame_word[31];
                        shift_out <= frame_word;
                        div_cnt   <= 8'h0;
                        bit_cnt   <= 6'h0;
                        state     <= S_XFER;
                    end
                end

                S_XFER: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= 8'h0;
                        if (!spi_clk) begin
                            spi_clk  <= 1'b1;
                            shift_in <= {shift_in[6:0], miso_s2};
                        end else begin
                            spi_clk   <= 1'b0;
                            shift_out <= {shift_out[30:0], 1'b0};
                            spi_mosi  <= shift_out[30];
                            bit_cnt   <= bit_cnt + 6'd1;
                            if (bit_cnt == frame_last) begin
                                state <= S_TAIL;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                S_TAIL: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= 8'h0;
                        spi_cs  <= 1'b1;
                        gap_cnt <= 16'h0;
                        case (kind)
                            K_WREN: begin
                                kind  <= K_CMD;
                                state <= S_GAP;
                            end
                            K_CMD: begin
                                if (is_wr) begin
`ifdef SPI_MEM_MASTER_WIP_POLL_EN
                                    kind  <= K_POLL;
                                    state <= S_GAP;
`else
                                    state <= S_DONE;
`endif
                                end else begin
                                    data_rd <= shift_in;
                                    state   <= S_DONE;
                                end
                            end
`ifdef SPI_MEM_MASTER_WIP_POLL_EN
                            K_POLL: begin
                                state <= shift_in[0] ? S_GAP : S_DONE;
                            end
`endif
                            default: state <= S_DONE;
                        endcase
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                S_DONE: begin
                    finish <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_master.sv
// tb_spi_mem_master: directed bench with a behavioural 25xx EEPROM model.
// Honours SPI_MEM_MASTER_WIP_POLL_EN to pick write-sequence expectations.
module tb_spi_mem_master;

    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 50;

    logic        mclk;
    logic        reset_n;
    logic        begin_rd;
    logic        begin_wr;
    logic        finish;
    logic [15:0] addr;
    logic [7:0]  data_wr;
    logic [7:0]  data_rd;
    logic        busy;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs;

    spi_mem_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .mclk     (mclk),
        .reset_n  (reset_n),
        .begin_rd (begin_rd),
        .begin_wr (begin_wr),
        .finish   (finish),
        .addr     (addr),
        .data_wr  (data_wr),
        .data_rd  (data_rd),
        .busy     (busy),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs   (spi_cs)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;

    // EEPROM model state
    logic [7:0]  mem [0:65535];
    int          m_cnt = 0;
    logic [31:0] m_word = 32'h0;
    logic [7:0]  m_cmd = 8'h0;
    logic [7:0]  m_out = 8'h0;
    logic [7:0]  m_status = 8'h0;
    logic [2:0]  m_idx;
    int          wip_left = 0;
    int          polls_cfg = 0;
    bit          in_frame = 0;
    logic [31:0] fr_word[$];
    int          fr_bits[$];

    // Monitor state
    int cyc = 0;
    int finish_cnt = 0;
    int finish_cyc = 0;
    int rise_cyc = 0;
    int high_cnt = 1000;
    int gap_viol = 0;
    int mosi_viol = 0;
    logic prev_cs = 1'b1;
    logic prev_clk = 1'b0;
    logic prev_mosi = 1'b0;

    // Frame start: the device resets its bit counter when CS falls.
    always @(negedge spi_cs) begin
        in_frame = 1;
        m_cnt    = 0;
        m_word   = 32'h0;
        m_cmd    = 8'h0;
        spi_miso = 1'b0;
    end

    // Frame end: log the frame and commit a complete WRITE.
    always @(posedge spi_cs) begin
        if (in_frame) begin
            in_frame = 0;
            fr_word.push_back(m_word);
            fr_bits.push_back(m_cnt);
            if (m_cnt == 32 && m_word[31:24] == 8'h02) begin
                mem[m_word[23:8]] = m_word[7:0];
                wip_left = polls_cfg;
            end
            spi_miso = 1'b0;
        end
    end

    // Device shifts MOSI in on SCK rise and presents the next MISO bit right away,
    // so each bit is stable for a full SCK period across the master's synchroniser.
    always @(posedge spi_clk) begin
        if (!spi_cs) begin
            m_word = {m_word[30:0], spi_mosi};
            m_cnt++;
            if (m_cnt == 8) begin
                m_cmd = m_word[7:0];
                if (m_cmd == 8'h05) begin
                    m_status = (wip_left > 0) ? 8'h01 : 8'h00;
                    if (wip_left > 0) wip_left--;
                end
            end
            if (m_cnt == 24 && m_cmd == 8'h03) m_out = mem[m_word[15:0]];
            spi_miso = 1'b0;
            if (m_cmd == 8'h03 && m_cnt >= 24 && m_cnt < 32) begin
                m_idx = 3'(31 - m_cnt);
                spi_miso = m_out[m_idx];
            end else if (m_cmd == 8'h05 && m_cnt >= 8 && m_cnt < 16) begin
                m_idx = 3'(15 - m_cnt);
                spi_miso = m_status[m_idx];
            end
        end
    end

    // Mid-cycle monitor: finish pulses, CS timing, CS gap and MOSI stability.
    always @(negedge mclk) begin
        cyc++;
        if (finish) begin
            finish_cnt++;
            finish_cyc = cyc;
        end
        if (spi_cs && !prev_cs) rise_cyc = cyc;
        if (spi_cs) begin
            high_cnt++;
        end else if (prev_cs) begin
            if (high_cnt < CS_GAP) gap_viol++;
            high_cnt = 0;
        end
        if (spi_mosi !== prev_mosi && prev_clk && spi_clk && !spi_cs) mosi_viol++;
        prev_cs   = spi_cs;
        prev_clk  = spi_clk;
        prev_mosi = spi_mosi;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic        pre;
        logic [7:0]  preload;
        int          polls;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
        @(negedge mclk);
        begin_rd = rd;
        begin_wr = wr;
        addr     = a;
        data_wr  = d;
        @(negedge mclk);
        begin_rd = 1'b0;
        begin_wr = 1'b0;
    endtask

    task automatic wait_finish(input int start, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge mclk);
            if (finish_cnt > start) begin
                ok = 1;
                break;
            end
        end
    endtask

    function automatic logic [31:0] frame_at(input int i);
        if (i < fr_word.size()) return fr_word[i];
        return 32'hxxxxxxxx;
    endfunction

    function automatic int bits_at(input int i);
        if (i < fr_bits.size()) return fr_bits[i];
        return -1;
    endfunction

    initial begin
        int f0;
        bit ok;
        int n_exp;
        vec_t v;

        vecs[0] = '{rd:1'b1, wr:1'b0, a:16'h1234, d:8'h00, pre:1'b1, preload:8'hA5, polls:0, exp_rd:8'hA5};
        vecs[1] = '{rd:1'b1, wr:1'b0, a:16'h0000, d:8'h00, pre:1'b1, preload:8'h3C, polls:0, exp_rd:8'h3C};
        vecs[2] = '{rd:1'b0, wr:1'b1, a:16'h00FF, d:8'h5A, pre:1'b0, preload:8'h00, polls:3, exp_rd:8'h3C};
        vecs[3] = '{rd:1'b1, wr:1'b1, a:16'h4321, d:8'hEE, pre:1'b1, preload:8'h81, polls:0, exp_rd:8'h81};
        vecs[4] = '{rd:1'b0, wr:1'b1, a:16'h0002, d:8'h11, pre:1'b0, preload:8'h00, polls:0, exp_rd:8'h81};
        vecs[5] = '{rd:1'b1, wr:1'b0, a:16'h00FF, d:8'h00, pre:1'b0, preload:8'h00, polls:0, exp_rd:8'h5A};

        begin_rd = 1'b0;
        begin_wr = 1'b0;
        addr     = 16'h0;
        data_wr  = 8'h0;
        spi_miso = 1'b0;
        reset_n  = 1'b0;
        repeat (3) @(negedge mclk);
        check_output("reset_cs",     32'(spi_cs),   32'h1);
        check_output("reset_clk",    32'(spi_clk),  32'h0);
        check_output("reset_mosi",   32'(spi_mosi), 32'h0);
        check_output("reset_finish", 32'(finish),   32'h0);
        check_output("reset_busy",   32'(busy),     32'h0);
        check_output("reset_data_rd", 32'(data_rd), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge mclk);

        for (int k = 0; k < 6; k++) begin
            v = vecs[k];
            fr_word.delete();
            fr_bits.delete();
            polls_cfg = v.polls;
            wip_left  = 0;
            if (v.pre) mem[v.a] = v.preload;
            f0 = finish_cnt;
            apply_stimulus(v.rd, v.wr, v.a, v.d);
            check_output($sformatf("v%0d_busy_after_begin", k), 32'(busy), 32'h1);
            wait_finish(f0, 5000, ok);
            check_output($sformatf("v%0d_finish_timeout", k), 32'(ok), 32'h1);
            repeat (5) @(negedge mclk);
            check_output($sformatf("v%0d_finish_count", k), 32'(finish_cnt - f0), 32'h1);
            check_output($sformatf("v%0d_busy_after", k), 32'(busy), 32'h0);
            check_output($sformatf("v%0d_data_rd", k), 32'(data_rd), 32'(v.exp_rd));
            check_output($sformatf("v%0d_finish_after_cs", k), 32'(finish_cyc - rise_cyc), 32'h1);
            if (v.rd) begin
                check_output($sformatf("v%0d_frames", k), 32'(fr_word.size()), 32'h1);
                check_output($sformatf("v%0d_rd_frame", k), frame_at(0), {8'h03, v.a, 8'h00});
                check_output($sformatf("v%0d_rd_bits", k), 32'(bits_at(0)), 32'd32);
                if (v.pre) check_output($sformatf("v%0d_mem_kept", k), 32'(mem[v.a]), 32'(v.preload));
            end else begin
`ifdef SPI_MEM_MASTER_WIP_POLL_EN
                n_exp = 3 + v.polls;
`else
                n_exp = 2;
`endif
                check_output($sformatf("v%0d_frames", k), 32'(fr_word.size()), 32'(n_exp));
                check_output($sformatf("v%0d_wren_frame", k), frame_at(0), 32'h06);
                check_output($sformatf("v%0d_wren_bits", k), 32'(bits_at(0)), 32'd8);
                check_output($sformatf("v%0d_wr_frame", k), frame_at(1), {8'h02, v.a, v.d});
                check_output($sformatf("v%0d_wr_bits", k), 32'(bits_at(1)), 32'd32);
                check_output($sformatf("v%0d_mem", k), 32'(mem[v.a]), 32'(v.d));
                for (int p = 2; p < n_exp; p++) begin
                    check_output($sformatf("v%0d_poll%0d_frame", k, p - 2), frame_at(p), 32'h0500);
                end
            end
        end

        // begin_wr while a read is in flight must be ignored.
        fr_word.delete();
        fr_bits.delete();
        mem[16'h0A0B] = 8'hC3;
        f0 = finish_cnt;
        apply_stimulus(1'b1, 1'b0, 16'h0A0B, 8'h00);
        repeat (20) @(negedge mclk);
        apply_stimulus(1'b0, 1'b1, 16'h0A0B, 8'h99);
        wait_finish(f0, 5000, ok);
        check_output("busy_wr_finish_timeout", 32'(ok), 32'h1);
        repeat (300) @(negedge mclk);
        check_output("busy_wr_finish_count", 32'(finish_cnt - f0), 32'h1);
        check_output("busy_wr_frames", 32'(fr_word.size()), 32'h1);
        check_output("busy_wr_frame", frame_at(0), 32'h030A0B00);
        check_output("busy_wr_data_rd", 32'(data_rd), 32'hC3);
        check_output("busy_wr_mem", 32'(mem[16'h0A0B]), 32'hC3);

        // Reset in the middle of the address phase.
        fr_word.delete();
        fr_bits.delete();
        f0 = finish_cnt;
        apply_stimulus(1'b1, 1'b0, 16'h5555, 8'h00);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge mclk);
            if (!spi_cs && m_cnt >= 12) begin
                ok = 1;
                break;
            end
        end
        check_output("midreset_reach_addr", 32'(ok), 32'h1);
        reset_n = 1'b0;
        #1;
        check_output("midreset_cs",      32'(spi_cs),  32'h1);
        check_output("midreset_clk",     32'(spi_clk), 32'h0);
        check_output("midreset_busy",    32'(busy),    32'h0);
        check_output("midreset_data_rd", 32'(data_rd), 32'h0);
        repeat (3) @(negedge mclk);
        reset_n = 1'b1;
        repeat (300) @(negedge mclk);
        check_output("midreset_no_finish", 32'(finish_cnt - f0), 32'h0);
        mem[16'hBEEF] = 8'h77;
        fr_word.delete();
        fr_bits.delete();
        f0 = finish_cnt;
        apply_stimulus(1'b1, 1'b0, 16'hBEEF, 8'h00);
        wait_finish(f0, 5000, ok);
        check_output("postreset_timeout", 32'(ok), 32'h1);
        check_output("postreset_data_rd", 32'(data_rd), 32'h77);
        check_output("postreset_frame", frame_at(0), 32'h03BEEF00);

        check_output("cs_gap_violations", 32'(gap_viol), 32'h0);
        check_output("mosi_high_changes", 32'(mosi_viol), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
